sump_cmd_decoder: RTL and testbench

Decodes the SUMP command byte stream delivered by the SPI slave into opcodes, 32-bit arguments, one-cycle action strobes and held configuration registers for the sampler, divider, controller and trigger stages. It sits between the SPI byte receiver and the capture core. It is the single point that configures the datapath from host commands: reset, run, ID query, divider, read/delay count, flags and trigger setup.

---
 rtl/sump_cmd_pkg.sv | 16 +
 rtl/sump_cmd_decoder_if.sv | 33 +++
 rtl/cmd_timeout_timer.sv | 20 ++
 rtl/sump_cmd_decoder.sv | 167 ++++++++++++++++
 tb/tb_sump_cmd_decoder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/sump_cmd_pkg.sv
// sump_cmd_pkg: opcodes, trigger selects and decoder state for the SUMP command decoder
package sump_cmd_pkg;
    localparam logic [7:0] OP_RESET     = 8'h00;
    localparam logic [7:0] OP_RUN       = 8'h01;
    localparam logic [7:0] OP_ID        = 8'h02;
    localparam logic [7:0] OP_META      = 8'h04;
    localparam logic [7:0] OP_DIVIDER   = 8'h80;
    localparam logic [7:0] OP_COUNT     = 8'h81;
    localparam logic [7:0] OP_FLAGS     = 8'h82;
    localparam logic [7:0] OP_TRIG_BASE = 8'hC0;
    localparam logic [1:0] TRIG_MASK    = 2'd0;
    localparam logic [1:0] TRIG_VALUE   = 2'd1;
    localparam logic [1:0] TRIG_CONFIG  = 2'd2;
    localparam logic [1:0] TRIG_RSVD    = 2'd3;
    typedef enum logic {ST_IDLE, ST_DATA} state_t;
endpackage

// File: rtl/sump_cmd_decoder_if.sv
// sump_cmd_decoder_if: byte input and decoded command/configuration outputs
interface sump_cmd_decoder_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;
    logic        soft_reset;
    logic        arm;
    logic        query_id;
    logic        query_meta;
    logic [23:0] divider;
    logic [15:0] read_count;
    logic [15:0] delay_count;
    logic [31:0] flags;
    logic        trig_wr;
    logic [1:0]  trig_stage;
    logic [1:0]  trig_sel;
    logic [31:0] trig_data;
    logic        timeout_err;
    modport master (
        output rx_valid, rx_data,
        input  cmd_valid, cmd_opcode, cmd_data, soft_reset, arm, query_id, query_meta,
               divider, read_count, delay_count, flags, trig_wr, trig_stage, trig_sel,
               trig_data, timeout_err
    );
    modport slave (
        input  rx_valid, rx_data,
        output cmd_valid, cmd_opcode, cmd_data, soft_reset, arm, query_id, query_meta,
               divider, read_count, delay_count, flags, trig_wr, trig_stage, trig_sel,
               trig_data, timeout_err
    );
endinterface

// File: rtl/cmd_timeout_timer.sv
// cmd_timeout_timer: counts idle cycles since clear; expire fires on the TIMEOUT_CYCLES-th idle cycle
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expire
);
    localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        expire = !clear && cnt_q == W'(TIMEOUT_CYCLES - 1);
        cnt_d  = (clear || expire) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sump_cmd_decoder.sv
// sump_cmd_decoder: SUMP byte stream to opcodes, strobes and held config registers
module sump_cmd_decoder
    import sump_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic              clk,
    input logic              rst,
    sump_cmd_decoder_if.slave bus
);
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;
    logic [7:0]  pend_q, pend_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_opcode_q, cmd_opcode_d;
    logic [31:0] cmd_data_q, cmd_data_d;
    logic        soft_reset_q, soft_reset_d;
    logic        arm_q, arm_d;
    logic        query_id_q, query_id_d;
    logic        query_meta_q, query_meta_d;
    logic [23:0] divider_q, divider_d;
    logic [15:0] read_count_q, read_count_d;
    logic [15:0] delay_count_q, delay_count_d;
    logic [31:0] flags_q, flags_d;
    logic        trig_wr_q, trig_wr_d;
    logic [1:0]  trig_stage_q, trig_stage_d;
    logic [1:0]  trig_sel_q, trig_sel_d;
    logic [31:0] trig_data_q, trig_data_d;
    logic        timeout_err_q, timeout_err_d;
    logic        expire;

`ifdef CMD_TIMEOUT_EN
    cmd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(clk),
        .rst(rst),
        .clear(state_q != ST_DATA || bus.rx_valid),
        .expire(expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        asm_d         = asm_q;
        pend_d        = pend_q;
        cmd_valid_d   = 1'b0;
        soft_reset_d  = 1'b0;
        arm_d         = 1'b0;
        query_id_d    = 1'b0;
        query_meta_d  = 1'b0;
        trig_wr_d     = 1'b0;
        timeout_err_d = 1'b0;
        cmd_opcode_d  = cmd_opcode_q;
        cmd_data_d    = cmd_data_q;
        divider_d     = divider_q;
        read_count_d  = read_count_q;
        delay_count_d = delay_count_q;
        flags_d       = flags_q;
        trig_stage_d  = trig_stage_q;
        trig_sel_d    = trig_sel_q;
        trig_data_d   = trig_data_q;
        if (expire) begin
            state_d       = ST_IDLE;
            timeout_err_d = 1'b1;
        end else if (bus.rx_valid && state_q == ST_IDLE && bus.rx_data[7]) begin
            state_d = ST_DATA;
            pend_d  = bus.rx_data;
            idx_d   = 2'd0;
            asm_d   = '0;
        end else if (bus.rx_valid && state_q == ST_IDLE) begin
            cmd_valid_d   = 1'b1;
            cmd_opcode_d  = bus.rx_data;
            cmd_data_d    = '0;
            soft_reset_d  = bus.rx_data == OP_RESET;
            arm_d         = bus.rx_data == OP_RUN;
            query_id_d    = bus.rx_data == OP_ID;
            query_meta_d  = bus.rx_data == OP_META;
            divider_d     = soft_reset_d ? '0 : divider_q;
            read_count_d  = soft_reset_d ? '0 : read_count_q;
            delay_count_d = soft_reset_d ? '0 : delay_count_q;
            flags_d       = soft_reset_d ? '0 : flags_q;
        end else if (bus.rx_valid) begin
            asm_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                state_d       = ST_IDLE;
                cmd_valid_d   = 1'b1;
                cmd_opcode_d  = pend_q;
                cmd_data_d    = asm_d;
                divider_d     = pend_q == OP_DIVIDER ? asm_d[23:0] : divider_q;
                read_count_d  = pend_q == OP_COUNT ? asm_d[15:0] : read_count_q;
                delay_count_d = pend_q == OP_COUNT ? asm_d[31:16] : delay_count_q;
                flags_d       = pend_q == OP_FLAGS ? asm_d : flags_q;
                trig_wr_d     = pend_q[7:4] == OP_TRIG_BASE[7:4];
                trig_stage_d  = trig_wr_d ? pend_q[3:2] : trig_stage_q;
                trig_sel_d    = trig_wr_d ? pend_q[1:0] : trig_sel_q;
                trig_data_d   = trig_wr_d ? asm_d : trig_data_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            asm_q         <= '0;
            pend_q        <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_opcode_q  <= '0;
            cmd_data_q    <= '0;
            soft_reset_q  <= 1'b0;
            arm_q         <= 1'b0;
            query_id_q    <= 1'b0;
            query_meta_q  <= 1'b0;
            divider_q     <= '0;
            read_count_q  <= '0;
            delay_count_q <= '0;
            flags_q       <= '0;
            trig_wr_q     <= 1'b0;
            trig_stage_q  <= '0;
            trig_sel_q    <= '0;
            trig_data_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            asm_q         <= asm_d;
            pend_q        <= pend_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_opcode_q  <= cmd_opcode_d;
            cmd_data_q    <= cmd_data_d;
            soft_reset_q  <= soft_reset_d;
            arm_q         <= arm_d;
            query_id_q    <= query_id_d;
            query_meta_q  <= query_meta_d;
            divider_q     <= divider_d;
            read_count_q  <= read_count_d;
            delay_count_q <= delay_count_d;
            flags_q       <= flags_d;
            trig_wr_q     <= trig_wr_d;
            trig_stage_q  <= trig_stage_d;
            trig_sel_q    <= trig_sel_d;
            trig_data_q   <= trig_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_opcode  = cmd_opcode_q;
    assign bus.cmd_data    = cmd_data_q;
    assign bus.soft_reset  = soft_reset_q;
    assign bus.arm         = arm_q;
    assign bus.query_id    = query_id_q;
    assign bus.query_meta  = query_meta_q;
    assign bus.divider     = divider_q;
    assign bus.read_count  = read_count_q;
    assign bus.delay_count = delay_count_q;
    assign bus.flags       = flags_q;
    assign bus.trig_wr     = trig_wr_q;
    assign bus.trig_stage  = trig_stage_q;
    assign bus.trig_sel    = trig_sel_q;
    assign bus.trig_data   = trig_data_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_sump_cmd_decoder.sv
// tb_sump_cmd_decoder: table-driven command vectors plus resync, async reset and timeout sequences
module tb_sump_cmd_decoder;
    typedef struct {
        int          n;
        logic [39:0] b;
        logic [6:0]  stb;
        logic [7:0]  op;
        logic [31:0] data;
        logic [23:0] div;
        logic [15:0] rc;
        logic [15:0] dc;
        logic [31:0] fl;
        logic [1:0]  ts;
        logic [1:0]  tsel;
        logic [31:0] td;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    vec_t v[12];
    logic [6:0] stb;

    sump_cmd_decoder_if bus ();

    sump_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign stb = {bus.cmd_valid, bus.soft_reset, bus.arm, bus.query_id, bus.query_meta,
                  bus.trig_wr, bus.timeout_err};

    function automatic vec_t mk(input int n, input logic [39:0] b, input logic [6:0] s,
                                input logic [7:0] op, input logic [31:0] data,
                                input logic [23:0] div, input logic [15:0] rc, input logic [15:0] dc,
                                input logic [31:0] fl, input logic [1:0] ts, input logic [1:0] tsel,
                                input logic [31:0] td);
        vec_t r;
        r.n = n; r.b = b; r.stb = s; r.op = op; r.data = data; r.div = div;
        r.rc = rc; r.dc = dc; r.fl = fl; r.ts = ts; r.tsel = tsel; r.td = td;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        v[0]  = mk(5, 40'h80_02_00_00_00, 7'b1000000, 8'h80, 32'h00000002, 24'h2,      16'h0,  16'h0,  32'h0,   2'd0, 2'd0, 32'h0);
        v[1]  = mk(5, 40'h81_FF_00_FF_00, 7'b1000000, 8'h81, 32'h00FF00FF, 24'h2,      16'hFF, 16'hFF, 32'h0,   2'd0, 2'd0, 32'h0);
        v[2]  = mk(5, 40'h82_38_08_00_00, 7'b1000000, 8'h82, 32'h00000838, 24'h2,      16'hFF, 16'hFF, 32'h838, 2'd0, 2'd0, 32'h0);
        v[3]  = mk(1, 40'h01_00_00_00_00, 7'b1010000, 8'h01, 32'h0,        24'h2,      16'hFF, 16'hFF, 32'h838, 2'd0, 2'd0, 32'h0);
        v[4]  = mk(1, 40'h02_00_00_00_00, 7'b1001000, 8'h02, 32'h0,        24'h2,      16'hFF, 16'hFF, 32'h838, 2'd0, 2'd0, 32'h0);
        v[5]  = mk(1, 40'h04_00_00_00_00, 7'b1000100, 8'h04, 32'h0,        24'h2,      16'hFF, 16'hFF, 32'h838, 2'd0, 2'd0, 32'h0);
        v[6]  = mk(1, 40'h11_00_00_00_00, 7'b1000000, 8'h11, 32'h0,        24'h2,      16'hFF, 16'hFF, 32'h838, 2'd0, 2'd0, 32'h0);
        v[7]  = mk(5, 40'hC2_00_00_00_08, 7'b1000010, 8'hC2, 32'h08000000, 24'h2,      16'hFF, 16'hFF, 32'h838, 2'd0, 2'd2, 32'h08000000);
        v[8]  = mk(5, 40'hC5_11_22_33_44, 7'b1000010, 8'hC5, 32'h44332211, 24'h2,      16'hFF, 16'hFF, 32'h838, 2'd1, 2'd1, 32'h44332211);
        v[9]  = mk(5, 40'h83_01_02_03_04, 7'b1000000, 8'h83, 32'h04030201, 24'h2,      16'hFF, 16'hFF, 32'h838, 2'd1, 2'd1, 32'h44332211);
        v[10] = mk(1, 40'h00_00_00_00_00, 7'b1100000, 8'h00, 32'h0,        24'h0,      16'h0,  16'h0,  32'h0,   2'd1, 2'd1, 32'h44332211);
        v[11] = mk(5, 40'h80_FF_FF_FF_FF, 7'b1000000, 8'h80, 32'hFFFFFFFF, 24'hFFFFFF, 16'h0,  16'h0,  32'h0,   2'd1, 2'd1, 32'h44332211);

        #3;
        chk("reset strobes", 32'(stb), 32'h0);
        chk("reset opcode", 32'(bus.cmd_opcode), 32'h0);
        chk("reset data", bus.cmd_data, 32'h0);
        chk("reset config", {bus.divider[7:0], bus.read_count[7:0], bus.delay_count[7:0], bus.flags[7:0]}, 32'h0);
        chk("reset trig", {bus.trig_data[27:0], bus.trig_stage, bus.trig_sel}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < v[k].n; j++) send(v[k].b[39 - 8*j -: 8]);
            chk($sformatf("v%0d strobes", k), 32'(stb), 32'(v[k].stb));
            chk($sformatf("v%0d opcode", k), 32'(bus.cmd_opcode), 32'(v[k].op));
            chk($sformatf("v%0d data", k), bus.cmd_data, v[k].data);
            chk($sformatf("v%0d divider", k), 32'(bus.divider), 32'(v[k].div));
            chk($sformatf("v%0d read_count", k), 32'(bus.read_count), 32'(v[k].rc));
            chk($sformatf("v%0d delay_count", k), 32'(bus.delay_count), 32'(v[k].dc));
            chk($sformatf("v%0d flags", k), bus.flags, v[k].fl);
            chk($sformatf("v%0d trig_stage", k), 32'(bus.trig_stage), 32'(v[k].ts));
            chk($sformatf("v%0d trig_sel", k), 32'(bus.trig_sel), 32'(v[k].tsel));
            chk($sformatf("v%0d trig_data", k), bus.trig_data, v[k].td);
            idle(1);
            chk($sformatf("v%0d strobes one cycle", k), 32'(stb), 32'h0);
        end

        send(8'h80); send(8'h12); send(8'h34);
        chk("resync partial quiet", 32'(stb), 32'h0);
        send(8'h00); send(8'h00);
        chk("resync complete strobes", 32'(stb), 32'h40);
        chk("resync complete data", bus.cmd_data, 32'h00003412);
        chk("resync divider", 32'(bus.divider), 32'h003412);
        send(8'h00);
        chk("resync soft_reset", 32'(stb), 32'h60);
        chk("resync divider cleared", 32'(bus.divider), 32'h0);
        send(8'h00); send(8'h00);
        chk("resync trailing reset", 32'(stb), 32'h60);
        idle(1);

        send(8'h82); send(8'h11);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        idle(1);
        chk("async rst strobes", 32'(stb), 32'h0);
        chk("async rst flags", bus.flags, 32'h0);
        send(8'h01);
        chk("after async rst arm", 32'(stb), 32'h50);
        idle(1);

`ifdef CMD_TIMEOUT_EN
        send(8'h81); send(8'hAA);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk);
                #1;
                seen = seen | bus.timeout_err | bus.cmd_valid;
            end
            chk("timeout early", 32'(seen), 32'h0);
        end
        idle(1);
        chk("timeout fires", 32'(stb), 32'h01);
        idle(1);
        chk("timeout one cycle", 32'(stb), 32'h0);
        send(8'h01);
        chk("timeout then arm", 32'(stb), 32'h50);
        idle(1);
        send(8'h81); send(8'hAA);
        idle(15);
        send(8'hBB);
        chk("byte at expiry wins", 32'(stb), 32'h0);
        send(8'hCC); send(8'hDD);
        chk("late command strobes", 32'(stb), 32'h40);
        chk("late command data", bus.cmd_data, 32'hDDCCBBAA);
        chk("late command read_count", 32'(bus.read_count), 32'hBBAA);
`else
        send(8'h81); send(8'hAA);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                seen = seen | bus.timeout_err | bus.cmd_valid;
            end
            chk("no timeout", 32'(seen), 32'h0);
        end
        send(8'h00); send(8'h00); send(8'h00);
        chk("partial survives idle", 32'(stb), 32'h40);
        chk("partial survives data", bus.cmd_data, 32'h000000AA);
`endif
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
